// File: rtl/pool_flatten.sv
// 2x2 stride-2 max pool of both 64x64 L0 maps into L1, plus channel-interleaved flatten into L2.
// 6 cycles per pooled pixel (4 reads, 2 writes); no backpressure, memory bus is fixed single-cycle.
module pool_flatten #(
  parameter int DW = 20,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  typedef enum logic [2:0] {IDLE, RD, WL1, WL2, FIN} state_t;

  state_t        state;
  logic          k;
  logic [9:0]    p;
  logic [1:0]    sub;
  logic [DW-1:0] max_q;
  logic [DW-1:0] max_nxt;
  logic [9:0]    p_nxt;
  logic          k_nxt;
  logic          last_pix;

  // Window offsets 0,+1,+64,+65 are just the row/column LSBs of the source address.
  function automatic logic [AW-1:0] rd_addr(input logic [9:0] pix, input logic [1:0] s);
    return AW'({pix[9:5], s[1], pix[4:0], s[0]});
  endfunction

  always_comb begin
    max_nxt  = (sub == 2'd0 || cdata_rd > max_q) ? cdata_rd : max_q;
    p_nxt    = p + 10'd1;
    k_nxt    = k | (p == 10'd1023);
    last_pix = k && (p == 10'd1023);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      csel     <= 3'b000;
      k        <= 1'b0;
      p        <= '0;
      sub      <= '0;
      max_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RD;
            busy     <= 1'b1;
            crd      <= 1'b1;
            csel     <= 3'b001;
            caddr_rd <= '0;
            k        <= 1'b0;
            p        <= '0;
            sub      <= '0;
          end
        end
        RD: begin
          max_q <= max_nxt;
          sub   <= sub + 2'd1;
          if (sub == 2'd3) begin
            state    <= WL1;
            crd      <= 1'b0;
            cwr      <= 1'b1;
            csel     <= 3'b011 + {2'b00, k};
            caddr_wr <= AW'({2'b00, p});
            cdata_wr <= max_nxt;
          end else begin
            caddr_rd <= rd_addr(p, sub + 2'd1);
          end
        end
        WL1: begin
          state    <= WL2;
          csel     <= 3'b101;
          caddr_wr <= AW'({1'b0, p, k});
        end
        WL2: begin
          cwr <= 1'b0;
          if (last_pix) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            csel  <= 3'b000;
          end else begin
            state    <= RD;
            crd      <= 1'b1;
            p        <= p_nxt;
            k        <= k_nxt;
            csel     <= k_nxt ? 3'b010 : 3'b001;
            caddr_rd <= rd_addr(p_nxt, 2'b00);
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_flatten.sv
// Bench for pool_flatten: memory models around the DUT, pooled/flattened image rebuilt from L0 with plain arithmetic.
module tb_pool_flatten;
  localparam int DW = 20;
  localparam int AW = 12;
  localparam int BUSY_CYCLES = 12288;
  localparam int TIMEOUT = 20000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done, crd, cwr;
  logic [AW-1:0] caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd, cdata_wr;
  logic [2:0]    csel;

  pool_flatten #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] l0 [2][4096];
  logic [DW-1:0] l1 [2][1024];
  logic [DW-1:0] l2 [2048];
  logic [DW-1:0] exp_l1 [2][1024];
  logic [DW-1:0] exp_l2 [2048];
  int offs [4] = '{0, 1, 64, 65};

  int n_checks = 0;
  int n_fail = 0;
  int busy_cnt, done_cnt, done_busy, done_long, overlap, bad_sel, wr_cnt;
  logic prev_done = 1'b0;

  assign cdata_rd = (csel == 3'b010) ? l0[1][caddr_rd] : l0[0][caddr_rd];

  always @(posedge clk) begin
    if (cwr) begin
      case (csel)
        3'b011:  l1[0][caddr_wr[9:0]] = cdata_wr;
        3'b100:  l1[1][caddr_wr[9:0]] = cdata_wr;
        3'b101:  l2[caddr_wr[10:0]] = cdata_wr;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (done && busy) done_busy++;
    if (done && prev_done) done_long++;
    if (crd && cwr) overlap++;
    if (cwr && !(csel inside {3'b011, 3'b100, 3'b101})) bad_sel++;
    if (crd && !(csel inside {3'b001, 3'b010})) bad_sel++;
    if (cwr) wr_cnt++;
    prev_done = done;
  end

  function automatic void prep_run();
    logic [DW-1:0] m;
    int base;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 1024; p++) begin
        base = (p / 32) * 128 + (p % 32) * 2;
        m = l0[k][base];
        for (int o = 1; o < 4; o++)
          if (l0[k][base + offs[o]] > m) m = l0[k][base + offs[o]];
        exp_l1[k][p] = m;
        exp_l2[2 * p + k] = m;
        l1[k][p] = 20'h5A5A5;
        l2[2 * p + k] = 20'h5A5A5;
      end
    end
  endfunction

  function automatic void fill_random();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 4096; a++) l0[k][a] = 20'($urandom);
  endfunction

  function automatic int l1_errors();
    int e = 0;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 1024; p++) if (l1[k][p] !== exp_l1[k][p]) e++;
    return e;
  endfunction

  function automatic int l2_errors();
    int e = 0;
    for (int i = 0; i < 2048; i++) if (l2[i] !== exp_l2[i]) e++;
    return e;
  endfunction

  task automatic clear_mon();
    busy_cnt = 0; done_cnt = 0; done_busy = 0; done_long = 0;
    overlap = 0; bad_sel = 0; wr_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rand_starts, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      start = rand_starts && busy && ($urandom_range(0, 40) == 0);
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if ({crd, cwr} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b expected 00", {crd, cwr}); end
    n_checks++; if ({caddr_rd, caddr_wr} !== '0) begin n_fail++; $display("FAIL reset_addr: got %h/%h expected 0/0", caddr_rd, caddr_wr); end
    n_checks++; if (cdata_wr !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", cdata_wr); end
    n_checks++; if (csel !== 3'b000) begin n_fail++; $display("FAIL reset_csel: got %b expected 000", csel); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_ramp_interleave();
    bit to;
    int e;
    for (int a = 0; a < 4096; a++) begin
      l0[0][a] = 20'(a);
      l0[1][a] = 20'h12345;
    end
    prep_run();
    clear_mon();
    start_job();
    wait_done(1'b0, to);
    step();
    n_checks++; if (to) begin n_fail++; $display("FAIL ramp_timeout: done not seen within %0d cycles", TIMEOUT); end
    n_checks++; if (l1[0][0] !== 20'h00041) begin n_fail++; $display("FAIL ramp_l1_0: got %h expected 00041", l1[0][0]); end
    n_checks++; if (l1[0][1] !== 20'h00043) begin n_fail++; $display("FAIL ramp_l1_1: got %h expected 00043", l1[0][1]); end
    n_checks++; if (l1[0][1023] !== 20'h00FFF) begin n_fail++; $display("FAIL ramp_l1_1023: got %h expected 00FFF", l1[0][1023]); end
    n_checks++; if (l2[0] !== 20'h00041) begin n_fail++; $display("FAIL ilv_l2_0: got %h expected 00041", l2[0]); end
    n_checks++; if (l2[1] !== 20'h12345) begin n_fail++; $display("FAIL ilv_l2_1: got %h expected 12345", l2[1]); end
    n_checks++; if (l2[2] !== 20'h00043) begin n_fail++; $display("FAIL ilv_l2_2: got %h expected 00043", l2[2]); end
    n_checks++; if (l2[2047] !== 20'h12345) begin n_fail++; $display("FAIL ilv_l2_2047: got %h expected 12345", l2[2047]); end
    e = 0;
    for (int p = 0; p < 1024; p++) if (l1[1][p] !== 20'h12345) e++;
    n_checks++; if (e != 0) begin n_fail++; $display("FAIL ilv_l1_ch1: %0d entries differ from 12345, expected 0", e); end
    e = l1_errors() + l2_errors();
    n_checks++; if (e != 0) begin n_fail++; $display("FAIL ramp_image: %0d entries wrong, expected 0", e); end
  endtask

  task automatic test_max_unsigned();
    logic [DW-1:0] win [8][4];
    bit to;
    int e;
    for (int j = 0; j < 4; j++)
      for (int o = 0; o < 4; o++)
        win[j][o] = (o == j) ? 20'h9 : 20'((o < j) ? o + 1 : o);
    win[4] = '{20'h9, 20'h3, 20'h9, 20'h2};
    win[5] = '{20'h9, 20'h9, 20'h9, 20'h9};
    win[6] = '{20'h7FFFF, 20'h80000, 20'h00000, 20'hFFFFF};
    win[7] = '{20'h7FFFF, 20'h80000, 20'h00000, 20'h00000};
    fill_random();
    for (int p = 0; p < 8; p++)
      for (int o = 0; o < 4; o++) l0[0][p * 2 + offs[o]] = win[p][o];
    prep_run();
    clear_mon();
    start_job();
    wait_done(1'b0, to);
    step();
    n_checks++; if (to) begin n_fail++; $display("FAIL maxpos_timeout: done not seen within %0d cycles", TIMEOUT); end
    for (int p = 0; p < 6; p++) begin
      n_checks++;
      if (l1[0][p] !== 20'h00009) begin n_fail++; $display("FAIL maxpos_%0d: got %h expected 00009", p, l1[0][p]); end
    end
    n_checks++; if (l1[0][6] !== 20'hFFFFF) begin n_fail++; $display("FAIL unsigned_a: got %h expected FFFFF", l1[0][6]); end
    n_checks++; if (l1[0][7] !== 20'h80000) begin n_fail++; $display("FAIL unsigned_b: got %h expected 80000", l1[0][7]); end
    n_checks++; if (l2[14] !== 20'h80000) begin n_fail++; $display("FAIL unsigned_l2: got %h expected 80000", l2[14]); end
    e = l1_errors() + l2_errors();
    n_checks++; if (e != 0) begin n_fail++; $display("FAIL random_image: %0d entries wrong, expected 0", e); end
  endtask

  task automatic test_protocol();
    logic [AW+4:0] seq [7];
    logic [AW+4:0] got;
    bit to;
    int e;
    fill_random();
    prep_run();
    seq[0] = {2'b10, 3'b001, 12'd0};
    seq[1] = {2'b10, 3'b001, 12'd1};
    seq[2] = {2'b10, 3'b001, 12'd64};
    seq[3] = {2'b10, 3'b001, 12'd65};
    seq[4] = {2'b01, 3'b011, 12'd0};
    seq[5] = {2'b01, 3'b101, 12'd0};
    seq[6] = {2'b10, 3'b001, 12'd2};
    clear_mon();
    start_job();
    for (int c = 0; c < 7; c++) begin
      got = {crd, cwr, csel, crd ? caddr_rd : caddr_wr};
      n_checks++;
      if (got !== seq[c] || busy !== 1'b1) begin
        n_fail++; $display("FAIL seq_cycle%0d: got %h busy %b expected %h busy 1", c + 1, got, busy, seq[c]);
      end
      if (c == 4) begin
        n_checks++;
        if (cdata_wr !== exp_l1[0][0]) begin n_fail++; $display("FAIL first_wdata: got %h expected %h", cdata_wr, exp_l1[0][0]); end
      end
      step();
    end
    wait_done(1'b1, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL proto_timeout: done not seen within %0d cycles", TIMEOUT); end
    n_checks++; if ({busy, done, crd, cwr} !== 4'b0100) begin n_fail++; $display("FAIL fin_cycle: busy/done/crd/cwr got %b expected 0100", {busy, done, crd, cwr}); end
    start = 1'b1;
    step();
    n_checks++; if (busy_cnt != BUSY_CYCLES) begin n_fail++; $display("FAIL busy_len: got %0d expected %0d", busy_cnt, BUSY_CYCLES); end
    n_checks++; if (done_cnt != 1 || done_long != 0 || done_busy != 0) begin n_fail++; $display("FAIL done_pulse: got %0d pulses/%0d long/%0d busy expected 1/0/0", done_cnt, done_long, done_busy); end
    n_checks++; if (overlap != 0) begin n_fail++; $display("FAIL rd_wr_overlap: got %0d expected 0", overlap); end
    n_checks++; if (bad_sel != 0) begin n_fail++; $display("FAIL bad_csel: got %0d expected 0", bad_sel); end
    n_checks++; if (wr_cnt != 4096) begin n_fail++; $display("FAIL write_count: got %0d expected 4096", wr_cnt); end
    e = l1_errors() + l2_errors();
    n_checks++; if (e != 0) begin n_fail++; $display("FAIL proto_image: %0d entries wrong, expected 0", e); end
    n_checks++; if ({busy, done, crd} !== 3'b000) begin n_fail++; $display("FAIL fin_start_ignored: busy/done/crd got %b expected 000", {busy, done, crd}); end
    step();
    start = 1'b0;
    n_checks++; if ({busy, crd, csel, caddr_rd} !== {2'b11, 3'b001, 12'd0}) begin n_fail++; $display("FAIL idle_start_accepted: busy %b crd %b csel %b addr %h", busy, crd, csel, caddr_rd); end
  endtask

  task automatic test_reset_mid_run();
    bit to;
    int e;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_entry_busy: got %b expected 1", busy); end
    repeat (499) step();
    reset = 1'b1;
    step();
    n_checks++;
    if ({busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: busy %b done %b crd %b cwr %b ard %h awr %h wd %h csel %b expected all 0",
                        busy, done, crd, cwr, caddr_rd, caddr_wr, cdata_wr, csel);
    end
    reset = 1'b0;
    e = 0;
    repeat (3) begin
      step();
      if (busy || crd || cwr || done) e++;
    end
    n_checks++; if (e != 0) begin n_fail++; $display("FAIL mid_reset_idle: %0d active cycles, expected 0", e); end
    fill_random();
    prep_run();
    clear_mon();
    start_job();
    n_checks++; if ({crd, csel, caddr_rd} !== {1'b1, 3'b001, 12'd0}) begin n_fail++; $display("FAIL rerun_first: crd %b csel %b addr %h expected 1 001 000", crd, csel, caddr_rd); end
    wait_done(1'b0, to);
    step();
    n_checks++; if (to) begin n_fail++; $display("FAIL rerun_timeout: done not seen within %0d cycles", TIMEOUT); end
    n_checks++; if (busy_cnt != BUSY_CYCLES) begin n_fail++; $display("FAIL rerun_busy_len: got %0d expected %0d", busy_cnt, BUSY_CYCLES); end
    e = l1_errors() + l2_errors();
    n_checks++; if (e != 0) begin n_fail++; $display("FAIL rerun_image: %0d entries wrong, expected 0", e); end
  endtask

  initial begin
    test_reset();
    test_ramp_interleave();
    test_max_unsigned();
    test_protocol();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
